// File: rtl/reg_file.sv
// Purpose: RV32I architectural register file, 32 x DATA_WIDTH, x0 reads zero, write-to-read bypass.
// Latency: reads are combinational (0 cycles); writes commit on the next CLK rising edge.
// Backpressure: none; every write request is accepted in its cycle (x0 writes are dropped).
module reg_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  REG_WRITE_EN,
  input  logic [ADDR_WIDTH-1:0] WRITE_ADDR,
  input  logic [DATA_WIDTH-1:0] WRITE_DATA,
  input  logic [ADDR_WIDTH-1:0] READ_ADDR1,
  input  logic [ADDR_WIDTH-1:0] READ_ADDR2,
  output logic [DATA_WIDTH-1:0] REG_READ1,
  output logic [DATA_WIDTH-1:0] REG_READ2,
  input  logic [ADDR_WIDTH-1:0] DBG_ADDR,
  output logic [DATA_WIDTH-1:0] DBG_DATA,
  output logic [CNT_WIDTH-1:0]  WR_COUNT
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // Entry 0 has no storage; it is supplied as a constant in the read view.
  logic [DATA_WIDTH-1:0] regs_q [1:DEPTH-1];
  logic [DATA_WIDTH-1:0] rd_view [DEPTH];
  logic [CNT_WIDTH-1:0]  wr_count_q, wr_count_d;
  logic                  wr_commit;
  logic                  byp1, byp2;
  logic [DATA_WIDTH-1:0] rd1_stored, rd2_stored;

  assign wr_commit = REG_WRITE_EN && (WRITE_ADDR != '0);

  // Storage: async clear, each entry loads only when it is the committed destination.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int i = 1; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        if (wr_commit && (WRITE_ADDR == ADDR_WIDTH'(i))) begin
          regs_q[i] <= WRITE_DATA;
        end
      end
    end
  end

  // Committed-write counter next state; wraps naturally at 2**CNT_WIDTH.
  always_comb begin
    wr_count_d = wr_count_q;
    if (wr_commit) begin
      wr_count_d = wr_count_q + CNT_WIDTH'(1);
    end
  end

  // Counter register.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wr_count_q <= '0;
    end else begin
      wr_count_q <= wr_count_d;
    end
  end

  // Fully decoded read view of committed state, index 0 tied to zero.
  always_comb begin
    rd_view[0] = '0;
    for (int i = 1; i < DEPTH; i++) begin
      rd_view[i] = regs_q[i];
    end
  end

  // Bypass selects are gated by reset and never fire for x0.
  assign byp1 = RSTN && REG_WRITE_EN && (READ_ADDR1 != '0) && (WRITE_ADDR == READ_ADDR1);
  assign byp2 = RSTN && REG_WRITE_EN && (READ_ADDR2 != '0) && (WRITE_ADDR == READ_ADDR2);

  assign rd1_stored = rd_view[READ_ADDR1];
  assign rd2_stored = rd_view[READ_ADDR2];

  // Bypass kept as the last mux so WRITE_DATA sees a single mux level to the ALU.
  assign REG_READ1 = byp1 ? WRITE_DATA : rd1_stored;
  assign REG_READ2 = byp2 ? WRITE_DATA : rd2_stored;

  // Debug port shows committed state only.
  assign DBG_DATA  = rd_view[DBG_ADDR];
  assign WR_COUNT  = wr_count_q;

endmodule

// File: tb/tb_reg_file.sv
// Purpose: scoreboard bench for reg_file; a default instance plus a CNT_WIDTH=4 instance for wrap.
// Latency: expectations are pushed when inputs are driven, popped and compared at the next falling edge.
// Backpressure: not applicable; every cycle produces one expectation.
module tb_reg_file;

  logic        CLK;
  logic        RSTN;
  logic        REG_WRITE_EN;
  logic [4:0]  WRITE_ADDR;
  logic [31:0] WRITE_DATA;
  logic [4:0]  READ_ADDR1;
  logic [4:0]  READ_ADDR2;
  logic [4:0]  DBG_ADDR;
  logic [31:0] REG_READ1, REG_READ2, DBG_DATA, WR_COUNT;
  logic [31:0] b_read1, b_read2, b_dbg;
  logic [3:0]  b_count;

  reg_file dut (
    .CLK(CLK), .RSTN(RSTN), .REG_WRITE_EN(REG_WRITE_EN), .WRITE_ADDR(WRITE_ADDR),
    .WRITE_DATA(WRITE_DATA), .READ_ADDR1(READ_ADDR1), .READ_ADDR2(READ_ADDR2),
    .REG_READ1(REG_READ1), .REG_READ2(REG_READ2), .DBG_ADDR(DBG_ADDR),
    .DBG_DATA(DBG_DATA), .WR_COUNT(WR_COUNT)
  );

  reg_file #(.CNT_WIDTH(4)) dut4 (
    .CLK(CLK), .RSTN(RSTN), .REG_WRITE_EN(REG_WRITE_EN), .WRITE_ADDR(WRITE_ADDR),
    .WRITE_DATA(WRITE_DATA), .READ_ADDR1(READ_ADDR1), .READ_ADDR2(READ_ADDR2),
    .REG_READ1(b_read1), .REG_READ2(b_read2), .DBG_ADDR(DBG_ADDR),
    .DBG_DATA(b_dbg), .WR_COUNT(b_count)
  );

  typedef struct {
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] dbg;
    logic [31:0] cnt;
    logic [3:0]  cnt4;
    int          tag;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_regs [32];
  int unsigned model_cnt;
  int          n_tests;
  int          n_fail;
  int          step_no;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string name, input int tag, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", name, tag, act, req);
    end
  endtask

  // Monitor: outputs are combinational, so each falling edge presents one response.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("read1", e.tag, REG_READ1, e.r1);
        check("read2", e.tag, REG_READ2, e.r2);
        check("dbg", e.tag, DBG_DATA, e.dbg);
        check("wr_count", e.tag, WR_COUNT, e.cnt);
        check("wr_count4", e.tag, {28'd0, b_count}, {28'd0, e.cnt4});
      end
    end
  end

  // Reference read: zero in reset or for x0, pending write wins, else architectural state.
  function automatic logic [31:0] ref_read(input logic rn, input logic we, input logic [4:0] wa,
                                           input logic [31:0] wd, input logic [4:0] a, input logic byp);
    if (!rn || a == 5'd0) return 32'd0;
    if (byp && we && wa == a) return wd;
    return model_regs[a];
  endfunction

  // One cycle: retire the write seen at this edge into the model, then drive the next inputs.
  task automatic step(input logic rn, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad);
    exp_t e;
    @(posedge CLK);
    if (RSTN && REG_WRITE_EN && WRITE_ADDR != 5'd0) begin
      model_regs[WRITE_ADDR] = WRITE_DATA;
      model_cnt++;
    end
    #1;
    RSTN = rn; REG_WRITE_EN = we; WRITE_ADDR = wa; WRITE_DATA = wd;
    READ_ADDR1 = a1; READ_ADDR2 = a2; DBG_ADDR = ad;
    if (!rn) begin
      foreach (model_regs[i]) model_regs[i] = 32'd0;
      model_cnt = 0;
    end
    step_no++;
    e.tag  = step_no;
    e.r1   = ref_read(rn, we, wa, wd, a1, 1'b1);
    e.r2   = ref_read(rn, we, wa, wd, a2, 1'b1);
    e.dbg  = ref_read(rn, we, wa, wd, ad, 1'b0);
    e.cnt  = model_cnt;
    e.cnt4 = model_cnt[3:0];
    exp_q.push_back(e);
  endtask

  initial begin
    logic [4:0]  wa, a1, a2, ad;
    logic        rn, we;
    int          guard;
    n_tests = 0; n_fail = 0; step_no = 0; model_cnt = 0;
    foreach (model_regs[i]) model_regs[i] = 32'd0;
    RSTN = 1'b0; REG_WRITE_EN = 1'b0; WRITE_ADDR = '0; WRITE_DATA = '0;
    READ_ADDR1 = '0; READ_ADDR2 = '0; DBG_ADDR = '0;

    // Reset, then load a few non-zero values.
    step(0, 0, 0, 0, 1, 2, 3);
    step(1, 0, 0, 0, 1, 2, 3);
    for (int i = 1; i < 8; i++) step(1, 1, 5'(i), $urandom | 32'h1, 5'(i), 5'(i - 1), 5'(i - 1));
    step(1, 0, 0, 0, 1, 2, 3);
    // Async reset between edges: everything reads zero immediately.
    step(0, 0, 0, 0, 1, 2, 3);
    step(1, 0, 0, 0, 4, 5, 6);

    // Basic write/read of x5.
    step(1, 1, 5, 32'hDEADBEEF, 0, 0, 0);
    step(1, 0, 0, 0, 5, 0, 5);

    // x0 write is dropped.
    step(1, 1, 0, 32'hFFFFFFFF, 0, 0, 0);
    step(1, 0, 0, 0, 0, 5, 0);

    // Bypass vs debug port on x7.
    step(1, 1, 7, 32'h11111111, 0, 0, 0);
    step(1, 1, 7, 32'h22222222, 7, 7, 7);
    step(1, 0, 0, 0, 7, 7, 7);

    // Reset in the same cycle as a write: the write is lost.
    step(0, 1, 3, 32'hA5A5A5A5, 3, 3, 3);
    step(1, 0, 0, 0, 3, 3, 3);
    step(1, 0, 0, 0, 3, 3, 3);

    // 17 committed writes with interleaved x0 writes: 4-bit counter wraps to 1.
    for (int i = 0; i < 17; i++) begin
      step(1, 1, 5'(1 + (i % 31)), $urandom, 5'(1 + (i % 31)), 0, 5'(1 + (i % 31)));
      step(1, 1, 0, $urandom, 0, 5'(1 + (i % 31)), 0);
    end
    step(1, 0, 0, 0, 1, 17, 17);

    // Randomized traffic, rare resets, frequent address collisions.
    for (int n = 0; n < 600; n++) begin
      rn = ($urandom_range(0, 59) != 0);
      we = ($urandom_range(0, 3) != 0);
      wa = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      a1 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom);
      a2 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom);
      ad = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom);
      step(rn, we, wa, $urandom, a1, a2, ad);
    end
    step(1, 0, 0, 0, 0, 0, 0);

    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(posedge CLK);
      guard++;
    end
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d responses still pending, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
